// File: rtl/counter_4b_if.sv
// Count output bundle for counter_4b: the counter drives q and a consumer reads it.
interface counter_4b_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] q;

    modport master (output q);
    modport slave  (input  q);
endinterface

// File: rtl/counter_4b.sv
// Free-running up-counter with a programmable terminal count and reset value.
// q comes straight from a register. Reset is asynchronous and active-low.
module counter_4b #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 32'((64'd1 << WIDTH) - 64'd1),
    parameter int unsigned RESET_VAL = 0
) (
    input  logic          clk,
    input  logic          reset,
    counter_4b_if.master  o_bus
);
    localparam logic [WIDTH-1:0] MaxQ   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ResetQ = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

    // Using >= rather than == also pulls an out-of-range state back to zero.
    always_comb begin
        w_q_next = r_q + WIDTH'(1);
        if (r_q >= MaxQ) begin
            w_q_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= ResetQ;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign o_bus.q = r_q;
endmodule

// File: tb/tb_counter_4b.sv
// Scoreboard bench for counter_4b: default instance plus a WIDTH=3/MAX_VAL=5/RESET_VAL=2 instance.
module tb_counter_4b;
    logic clk;
    logic reset;
    logic reset3;

    counter_4b_if #(.WIDTH(4)) bus  ();
    counter_4b_if #(.WIDTH(3)) bus3 ();

    counter_4b u_dut (
        .clk   (clk),
        .reset (reset),
        .o_bus (bus)
    );

    counter_4b #(
        .WIDTH     (3),
        .MAX_VAL   (5),
        .RESET_VAL (2)
    ) u_dut_w3 (
        .clk   (clk),
        .reset (reset3),
        .o_bus (bus3)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        string       name;
        bit          sel;
        int unsigned exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event sample_ev;

    // Monitor: drains all pending expectations each time a sample is announced.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = e.sel ? 32'(bus3.q) : 32'(bus.q);
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: q=%0d expected %0d at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_q(input string name, input bit sel, input int unsigned exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        reset3 = 1'b1;

        // Test 1: asynchronous assertion before any clock edge, then hold for two edges.
        #30;
        reset  = 1'b0;
        reset3 = 1'b0;
        #1;
        expect_q("async_reset", 1'b0, 0);
        expect_q("async_reset_w3", 1'b1, 2);
        @(negedge clk);
        expect_q("hold_reset_e1", 1'b0, 0);
        @(negedge clk);
        expect_q("hold_reset_e2", 1'b0, 0);

        // Tests 2/3: release and run 20 edges, wrapping 15 -> 0 on edge 16.
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            expect_q($sformatf("count_e%0d", i), 1'b0, i % 16);
        end

        // Test 4: count to 7, then a 30 ns reset pulse between edges.
        for (int v = 5; v <= 7; v++) begin
            @(negedge clk);
            expect_q($sformatf("to7_%0d", v), 1'b0, v);
        end
        #9;
        reset = 1'b0;
        #1;
        expect_q("pulse_reset", 1'b0, 0);
        #29;
        reset = 1'b1;
        @(negedge clk);
        expect_q("after_pulse", 1'b0, 1);

        // Test 5: reset asserted on the rising edge while q=9.
        for (int v = 2; v <= 9; v++) begin
            @(negedge clk);
            expect_q($sformatf("to9_%0d", v), 1'b0, v);
        end
        @(posedge clk);
        reset = 1'b0;
        #1;
        expect_q("edge_reset", 1'b0, 0);
        @(negedge clk);
        expect_q("edge_reset_hold", 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        expect_q("edge_release_1", 1'b0, 1);
        @(negedge clk);
        expect_q("edge_release_2", 1'b0, 2);

        // Test 6: reduced instance counts 2 -> 3,4,5,0,1,2,3 and recovers from q=7.
        expect_q("w3_reset_val", 1'b1, 2);
        reset3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            int unsigned exp3;
            exp3 = (3 + i) % 6;
            @(negedge clk);
            expect_q($sformatf("w3_step%0d", i), 1'b1, exp3);
        end
        force u_dut_w3.r_q = 3'd7;
        #1;
        release u_dut_w3.r_q;
        @(negedge clk);
        expect_q("w3_out_of_range", 1'b1, 0);
        @(negedge clk);
        expect_q("w3_after_recover", 1'b1, 1);

        -> sample_ev;
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
